// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-port SRAM macro between two requesters. At most one
// command is granted per cycle. A lone requester is granted in the same
// cycle it asks. When both ask, the winner depends on the build:
//   SRAM_ARB_RR_EN defined   : round-robin; the requester not granted last wins
//   SRAM_ARB_RR_EN undefined : fixed priority; requester 0 always wins
// A granted command drives the macro in the same cycle. A read's data
// returns on the granted requester's response port one cycle later.
//
// Ports
//   clock            single clock, all logic on posedge
//   reset            synchronous, active-high
//   reqN_valid       requester N has a command pending
//   reqN_ready       requester N's command is accepted this cycle
//   reqN_we          1 = write, 0 = read
//   reqN_addr        word address
//   reqN_wdata       write data
//   rspN_valid       read data for requester N is valid this cycle
//   rspN_rdata       read data for requester N (zero when not valid)
//   sram_ce          macro chip enable
//   sram_we          macro write enable
//   sram_addr        macro address (holds its last value when idle)
//   sram_wd          macro write data (holds its last value when idle)
//   sram_rd          macro read data, valid one cycle after a read access
module sram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,

  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wd,
  input  logic [DATA_W-1:0] sram_rd
);

`ifdef SRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Arbitration and response-tracking state.
  logic              last_grant;
  logic              rsp_pending;
  logic              rsp_id;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wd;

  logic              grant0;
  logic              grant1;
  logic              any_grant;
  logic              contend_pick1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;

  // On contention requester 1 wins only in round-robin mode, and only when
  // requester 0 was the last one served. last_grant is tracked in both modes
  // so that switching builds never changes the state behaviour.
  assign contend_pick1 = RR_EN & ~last_grant;

  // Grant decision. Nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~contend_pick1;
        grant1 = contend_pick1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign any_grant  = grant0 | grant1;

  // The winning command's fields.
  assign sel_we   = grant1 ? req1_we    : req0_we;
  assign sel_addr = grant1 ? req1_addr  : req0_addr;
  assign sel_wd   = grant1 ? req1_wdata : req0_wdata;

  // Macro drive. When idle, address and data hold the last driven values so
  // the macro never sees X. Reset forces them to zero immediately.
  always_comb begin
    sram_ce   = any_grant;
    sram_we   = any_grant & sel_we;
    sram_addr = hold_addr;
    sram_wd   = hold_wd;
    if (reset) begin
      sram_addr = '0;
      sram_wd   = '0;
    end else if (any_grant) begin
      sram_addr = sel_addr;
      sram_wd   = sel_wd;
    end
  end

  // State register. A read grant leaves one pending response for the next
  // cycle, tagged with the granted requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant  <= 1'b1;
      rsp_pending <= 1'b0;
      rsp_id      <= 1'b0;
      hold_addr   <= '0;
      hold_wd     <= '0;
    end else begin
      rsp_pending <= any_grant & ~sel_we;
      rsp_id      <= grant1;
      if (any_grant) begin
        last_grant <= grant1;
        hold_addr  <= sel_addr;
        hold_wd    <= sel_wd;
      end
    end
  end

  // Response ports. Gating with reset suppresses a response that was pending
  // when reset arrived.
  always_comb begin
    rsp0_valid = !reset && rsp_pending && !rsp_id;
    rsp1_valid = !reset && rsp_pending &&  rsp_id;
    rsp0_rdata = rsp0_valid ? sram_rd : '0;
    rsp1_rdata = rsp1_valid ? sram_rd : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//
// Self-checking bench for sram_port_arbiter. It includes a simple
// synchronous SRAM model that the DUT drives. A behavioural reference model
// (a shadow memory plus the arbitration rules) is checked against every DUT
// output on every negative clock edge. Directed sequences add literal
// expectations, and a randomized phase follows. The bench follows
// SRAM_ARB_RR_EN, so it matches the build it is compiled with.
module tb_sram_port_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid, req0_ready, req0_we;
  logic [7:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [7:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        sram_ce, sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wd;
  logic [31:0] sram_rd = '0;

  logic [31:0] mem [256] = '{default: '0};

  int total = 0;
  int bad   = 0;

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wd    (sram_wd),
    .sram_rd    (sram_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM macro model: synchronous write, read data one cycle after access.
  always @(posedge clock) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wd;
      else         sram_rd <= mem[sram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic we0, input logic [7:0] a0, input logic [31:0] d0,
                               input logic v1, input logic we1, input logic [7:0] a1, input logic [31:0] d1);
    @(posedge clock);
    #1;
    reset      = rst;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  // Reference model: what the specification says each output must be.
  logic [31:0] shadow [256] = '{default: '0};
  logic        m_last     = 1'b1;
  logic        m_rsp_v    = 1'b0;
  logic        m_rsp_id   = 1'b0;
  logic [31:0] m_rsp_data = '0;
  logic [7:0]  m_addr     = '0;
  logic [31:0] m_wd       = '0;

  always @(negedge clock) begin : compare
    logic        e0, e1, eany, ew, ev0, ev1;
    logic [7:0]  ea;
    logic [31:0] ed;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
`ifdef SRAM_ARB_RR_EN
        if (m_last) e0 = 1'b1;
        else        e1 = 1'b1;
`else
        e0 = 1'b1;
`endif
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    eany = e0 | e1;
    ew = e1 ? req1_we    : req0_we;
    ea = e1 ? req1_addr  : req0_addr;
    ed = e1 ? req1_wdata : req0_wdata;

    ev0 = !reset && m_rsp_v && (m_rsp_id == 1'b0);
    ev1 = !reset && m_rsp_v && (m_rsp_id == 1'b1);

    checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
    checkOutput("sram_ce", 32'(sram_ce), 32'(eany));
    checkOutput("sram_we", 32'(sram_we), 32'(eany & ew));
    checkOutput("sram_addr", 32'(sram_addr), reset ? 32'd0 : (eany ? 32'(ea) : 32'(m_addr)));
    checkOutput("sram_wd", sram_wd, reset ? 32'd0 : (eany ? ed : m_wd));
    checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    checkOutput("rsp0_rdata", rsp0_rdata, ev0 ? m_rsp_data : 32'd0);
    checkOutput("rsp1_rdata", rsp1_rdata, ev1 ? m_rsp_data : 32'd0);

    // Advance the model to what the coming rising edge produces.
    if (reset) begin
      m_last  = 1'b1;
      m_rsp_v = 1'b0;
      m_addr  = '0;
      m_wd    = '0;
    end else begin
      m_rsp_v = 1'b0;
      if (eany) begin
        m_last = e1;
        m_addr = ea;
        m_wd   = ed;
        if (ew) begin
          shadow[ea] = ed;
        end else begin
          m_rsp_v    = 1'b1;
          m_rsp_id   = e1;
          m_rsp_data = shadow[ea];
        end
      end
    end
  end

  logic        g0, g1, rst_r;
  logic        n_v0, n_we0, n_v1, n_we1;
  logic [7:0]  n_a0, n_a1;
  logic [31:0] n_d0, n_d1;
  int          winner, prev_winner;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

    // Reset state.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("reset_ready0", 32'(req0_ready), 32'd0);
    checkOutput("reset_ce", 32'(sram_ce), 32'd0);
    checkOutput("reset_addr", 32'(sram_addr), 32'd0);
    checkOutput("reset_rsp0", 32'(rsp0_valid), 32'd0);

    // Write then read-back on requester 0.
    applyStimulus(0, 1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("wr_ready0", 32'(req0_ready), 32'd1);
    checkOutput("wr_sram_we", 32'(sram_we), 32'd1);
    checkOutput("wr_sram_addr", 32'(sram_addr), 32'h10);
    applyStimulus(0, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("rd_ready0", 32'(req0_ready), 32'd1);
    checkOutput("wr_no_rsp", 32'(rsp0_valid), 32'd0);
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("rd_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("rd_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
    checkOutput("rd_rsp1_valid", 32'(rsp1_valid), 32'd0);

    // Requester 1 writes the top address, requester 0 reads it next cycle.
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 1, 1, 8'hFF, 32'h5);
    @(negedge clock);
    checkOutput("ff_wr_ready1", 32'(req1_ready), 32'd1);
    applyStimulus(0, 1, 0, 8'hFF, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("ff_rsp0_rdata", rsp0_rdata, 32'h5);

    // Contention after reset: both read continuously for 6 cycles.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    prev_winner = -1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 8'h10, 32'h0, 1, 0, 8'hFF, 32'h0);
      @(negedge clock);
`ifdef SRAM_ARB_RR_EN
      winner = i % 2;
`else
      winner = 0;
`endif
      checkOutput("cont_ready0", 32'(req0_ready), (winner == 0) ? 32'd1 : 32'd0);
      checkOutput("cont_ready1", 32'(req1_ready), (winner == 1) ? 32'd1 : 32'd0);
      if (prev_winner == 0) checkOutput("cont_rsp0", rsp0_rdata, 32'hDEADBEEF);
      if (prev_winner == 1) checkOutput("cont_rsp1", rsp1_rdata, 32'h5);
      prev_winner = winner;
    end
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("cont_last_rsp0", 32'(rsp0_valid), (prev_winner == 0) ? 32'd1 : 32'd0);

    // Read grant followed by reset: the response is dropped.
    applyStimulus(0, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("rstrd_ready0", 32'(req0_ready), 32'd1);
    applyStimulus(1, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    checkOutput("rstrd_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rstrd_rsp0_rdata", rsp0_rdata, 32'd0);
    checkOutput("rstrd_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rstrd_ce", 32'(sram_ce), 32'd0);
    checkOutput("rstrd_addr", 32'(sram_addr), 32'd0);

    // Idle bus holds the last address.
    applyStimulus(0, 1, 1, 8'h33, 32'h1234, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
      @(negedge clock);
      checkOutput("idle_ce", 32'(sram_ce), 32'd0);
      checkOutput("idle_we", 32'(sram_we), 32'd0);
      checkOutput("idle_ready1", 32'(req1_ready), 32'd0);
      checkOutput("idle_addr", 32'(sram_addr), 32'h33);
    end

    // Randomized traffic. A requester that was not granted keeps its command.
    for (int n = 0; n < 1500; n++) begin
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      rst_r = ($urandom_range(0, 59) == 0);
      if (req0_valid && !g0) begin
        n_v0 = req0_valid; n_we0 = req0_we; n_a0 = req0_addr; n_d0 = req0_wdata;
      end else begin
        n_v0  = ($urandom_range(0, 9) < 7);
        n_we0 = $urandom_range(0, 1) == 1;
        n_a0  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        n_d0  = $urandom();
      end
      if (req1_valid && !g1) begin
        n_v1 = req1_valid; n_we1 = req1_we; n_a1 = req1_addr; n_d1 = req1_wdata;
      end else begin
        n_v1  = ($urandom_range(0, 9) < 7);
        n_we1 = $urandom_range(0, 1) == 1;
        n_a1  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        n_d1  = $urandom();
      end
      applyStimulus(rst_r, n_v0, n_we0, n_a0, n_d0, n_v1, n_we1, n_a1, n_d1);
      @(negedge clock);
    end

    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
